// File: rtl/mfp_ahb_sdram_arbiter.sv
// Two-master AHB-Lite front end for the single SDRAM slave: each address phase is captured, the master is
// stalled (HREADY low) and the beat is replayed to the slave as a SINGLE; overhead is 2 cycles, slave HREADYOUT backpressures both.
module mfp_ahb_sdram_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,

  input  logic        m0_HSEL,
  input  logic [31:0] m0_HADDR,
  input  logic [1:0]  m0_HTRANS,
  input  logic        m0_HWRITE,
  input  logic [2:0]  m0_HSIZE,
  input  logic [31:0] m0_HWDATA,
  output logic [31:0] m0_HRDATA,
  output logic        m0_HREADY,
  output logic        m0_HRESP,

  input  logic        m1_HSEL,
  input  logic [31:0] m1_HADDR,
  input  logic [1:0]  m1_HTRANS,
  input  logic        m1_HWRITE,
  input  logic [2:0]  m1_HSIZE,
  input  logic [31:0] m1_HWDATA,
  output logic [31:0] m1_HRDATA,
  output logic        m1_HREADY,
  output logic        m1_HRESP,

  output logic        s_HSEL,
  output logic [31:0] s_HADDR,
  output logic [1:0]  s_HTRANS,
  output logic        s_HWRITE,
  output logic [2:0]  s_HSIZE,
  output logic [2:0]  s_HBURST,
  output logic        s_HREADY,
  output logic [31:0] s_HWDATA,
  input  logic [31:0] s_HRDATA,
  input  logic        s_HREADYOUT,
  input  logic        s_HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } slot_t;

  state_t      state, state_nxt;
  slot_t       slot [2];
  logic [1:0]  pend;
  logic [1:0]  acc;
  logic        gnt, last_gnt, win, done;
  logic        unused_ok;

  assign done = (state == S_DATA) & s_HREADYOUT;

  // The owning master sees HREADY high in its completion cycle so it can
  // present its next address phase without a bubble.
  assign m0_HREADY = ~pend[0] | (done & ~gnt);
  assign m1_HREADY = ~pend[1] | (done &  gnt);

  assign acc[0] = m0_HSEL & m0_HTRANS[1] & m0_HREADY;
  assign acc[1] = m1_HSEL & m1_HTRANS[1] & m1_HREADY;

  always_comb begin
    win = ~pend[0];
    if (!PRIO_FIXED && (&pend))
      win = ~last_gnt;
  end

  always_comb begin
    state_nxt = state;
    s_HSEL    = 1'b0;
    s_HTRANS  = 2'b00;
    case (state)
      S_IDLE: begin
        if (|pend)
          state_nxt = S_ADDR;
      end
      S_ADDR: begin
        s_HSEL   = 1'b1;
        s_HTRANS = 2'b10;
        if (s_HREADYOUT)
          state_nxt = S_DATA;
      end
      S_DATA: begin
        if (s_HREADYOUT)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      pend     <= 2'b00;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      slot[0]  <= '0;
      slot[1]  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && (|pend)) begin
        gnt      <= win;
        last_gnt <= win;
      end
      // A fresh accept wins over the completion clear on the same edge.
      pend[0] <= acc[0] | (pend[0] & ~(done & ~gnt));
      pend[1] <= acc[1] | (pend[1] & ~(done &  gnt));
      if (acc[0])
        slot[0] <= '{addr: m0_HADDR, write: m0_HWRITE, size: m0_HSIZE};
      if (acc[1])
        slot[1] <= '{addr: m1_HADDR, write: m1_HWRITE, size: m1_HSIZE};
    end
  end

  assign s_HADDR  = slot[gnt].addr;
  assign s_HWRITE = slot[gnt].write;
  assign s_HSIZE  = slot[gnt].size;
  assign s_HBURST = 3'b000;
  assign s_HREADY = s_HREADYOUT;
  // Stalled masters hold HWDATA, so a direct mux is valid for the whole data phase.
  assign s_HWDATA = gnt ? m1_HWDATA : m0_HWDATA;

  assign m0_HRDATA = s_HRDATA;
  assign m1_HRDATA = s_HRDATA;
  assign m0_HRESP  = 1'b0;
  assign m1_HRESP  = 1'b0;

  assign unused_ok = ^{s_HRESP, m0_HTRANS[0], m1_HTRANS[0]};

endmodule

// File: doc/mfp_ahb_sdram_arbiter.md
# mfp_ahb_sdram_arbiter

Two-master AHB-Lite arbiter that shares the single SDRAM AHB-Lite slave (the MIPSfpga+ SDRAM controller) between master 0 (CPU bus) and master 1 (DMA/video). It captures each master's address phase, stalls that master, and replays the transfer to the slave as an isolated single transfer. It returns the slave's read data and ready to the owning master. Arbitration is round-robin by default, or fixed priority to master 0.

## Interface

- PRIO_FIXED, 0, 1: master 0 always wins ties. 0: round-robin between masters.
- HCLK  in  1  system clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- mN_HSEL  in  1  master N selects SDRAM region (N = 0, 1; applies to every mN_ line)
- mN_HADDR  in  32  master N address
- mN_HTRANS  in  2  master N transfer type; bit 1 set = NONSEQ/SEQ request
- mN_HWRITE  in  1  master N write
- mN_HSIZE  in  3  master N size (byte/half/word)
- mN_HWDATA  in  32  master N write data, held by master while stalled
- mN_HRDATA  out  32  read data to master N
- mN_HREADY  out  1  ready to master N; also its address-phase accept qualifier
- mN_HRESP  out  1  constant 0
- s_HSEL  out  1  slave select
- s_HADDR  out  32  slave address
- s_HTRANS  out  2  2'b10 during replayed address phase, else 2'b00
- s_HWRITE  out  1  slave write
- s_HSIZE  out  3  slave size
- s_HBURST  out  3  constant 3'b000 (SINGLE)
- s_HREADY  out  1  equals s_HREADYOUT
- s_HWDATA  out  32  write data of granted master
- s_HRDATA  in  32  slave read data
- s_HREADYOUT  in  1  slave ready
- s_HRESP  in  1  ignored

## Operation

- Accept condition for master N: mN_HSEL & mN_HTRANS[1] & mN_HREADY. On accept, latch HADDR, HWRITE and HSIZE into slot N and set pend[N].
- SEQ is treated as NONSEQ. Each beat is arbitrated separately.
- mN_HREADY = ~pend[N]. A master is therefore stalled from the cycle after its address phase until its transfer completes.
- FSM states:
  - IDLE: if any pend is set, choose the winner, register gnt, go to ADDR.
  - ADDR: drive slot[gnt] onto s_HADDR/s_HWRITE/s_HSIZE with s_HSEL=1 and s_HTRANS=2'b10. Stay while s_HREADYOUT=0, because the slave may be refreshing or initialising. Go to DATA on the edge where s_HREADYOUT=1.
  - DATA: s_HTRANS=0 and s_HSEL=0. Wait for s_HREADYOUT=1. In that cycle pend[gnt] clears, and the FSM goes to IDLE.
- Winner selection:
  - PRIO_FIXED=1: master 0 if pend[0], else master 1.
  - PRIO_FIXED=0: if both pend are set, the master other than last_gnt wins. last_gnt updates on the IDLE to ADDR transition.
- s_HWDATA = mN_HWDATA of gnt, combinational. This is valid because the stalled master holds HWDATA constant.
- mN_HRDATA = s_HRDATA for both masters, unmasked. It is meaningful only in the completion cycle of the granted master.
- A master whose HREADY rises may issue its next address phase in that same cycle; it is accepted normally.
- A request arriving while the other master is in service is only latched. It is served after the FSM returns to IDLE.

## Timing

- Reset values:
  - state IDLE, pend=2'b00, gnt=0, last_gnt=1 (master 0 wins the first tie), slots cleared.
  - mN_HREADY=1, s_HTRANS=0, s_HSEL=0.
- Latency, with the address phase accepted in cycle t:
  - t+1: pend set, mN_HREADY=0, FSM in IDLE.
  - t+2: slave address phase, provided s_HREADYOUT=1.
  - t+3 onward: data phase.
  - Completion: mN_HREADY=1 in the same cycle as s_HREADYOUT=1.
- Minimum overhead is 2 cycles over the slave's native latency.
- Simultaneous accepts from both masters in cycle t: both pend set at t+1, and one winner is chosen per the selection rule.
- A completion cycle and a new accept from the same master in the same cycle: pend clears and re-sets on the same edge, and re-set takes precedence. The request then competes in IDLE at the next cycle.
- HRESET asserted in any state: the reset values above hold on the next edge. The in-flight transfer is dropped, and the slave is reset by the same reset source.
- s_HADDR, s_HWRITE and s_HSIZE are stable for the entire ADDR state.

## Test plan

- m0 read 0x0000_0100 (slave preloaded 0xDEAD_BEEF):
  - t+1: m0_HREADY=0.
  - t+2: s_HTRANS=2, s_HADDR=0x100.
  - m0_HREADY=1 with m0_HRDATA=0xDEAD_BEEF in the cycle s_HREADYOUT rises.
- Same-cycle requests: m0 write 0x10=0xA5A5_1234 and m1 read 0x10.
  - m0 is served first.
  - m1 then reads 0xA5A5_1234.
  - m1_HREADY stays 0 throughout the m0 transfer.
- Both masters issuing back-to-back word reads:
  - PRIO_FIXED=0: grant sequence 0,1,0,1.
  - PRIO_FIXED=1: m1 is served only once m0 stops requesting.
- Slave model holds s_HREADYOUT=0 for 10 cycles (refresh) during ADDR: s_HTRANS=2 and s_HADDR remain unchanged for all 10 cycles, and DATA is entered only after release.
- m1 byte write, HSIZE=0, address 0x23, data 0x5500_0000: s_HSIZE=0, s_HADDR=0x23, s_HWDATA=0x5500_0000. Readback of word 0x20 shows only byte 3 changed.
- HRESET pulsed in DATA during an m0 read: next cycle m0_HREADY=1, m1_HREADY=1, s_HTRANS=0, pend=0. A subsequent m1 request completes normally.
